// File: rtl/row_lif_accumulator.sv
// row_lif_accumulator: per-column partial-sum accumulation with LIF thresholding and packet emission
module row_lif_accumulator #(
   parameter int NUM_COL   = 3,
   parameter int NUM_ACC   = 3,
   parameter int DATA_W    = 8,
   parameter int IN_W      = 39,
   parameter int COL_LSB   = 24,
   parameter int COL_W     = 2,
   parameter int ROW_W     = 2,
   parameter int ROW       = 1,
   parameter int THRESHOLD = 64,
   parameter int RST_MODE  = 0,
   localparam int OUT_W    = 2 + 8 + ROW_W + NUM_COL + NUM_COL * DATA_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             err
);
   localparam int CNT_W = $clog2(NUM_ACC + 1);
   localparam logic [1:0] ACCUM = 2'd0, FIRE = 2'd1, SEND = 2'd2;
   logic [1:0] state;
   logic [DATA_W-1:0] pot [NUM_COL];
   logic [CNT_W-1:0] cnt [NUM_COL];
   logic [DATA_W-1:0] fired [NUM_COL];
   logic [DATA_W-1:0] sat_sum [NUM_COL];
   logic [DATA_W:0] sum;
   logic [NUM_COL-1:0] full, take, spikes;
   logic [NUM_COL*DATA_W-1:0] pots;
   logic [COL_W-1:0] col;
   logic [DATA_W-1:0] partial;
   logic accept, drop, unused_bits;
   assign unused_bits = ^in_data;
   assign col = in_data[COL_LSB+:COL_W];
   assign partial = in_data[DATA_W-1:0];
   // Counts are only seen full one cycle after the final accept, so in_ready drops for that cycle
   assign in_ready = rst_n && state == ACCUM && !(&full);
   assign accept = in_valid && in_ready;
   assign drop = accept && take == '0;
   always_comb begin
      sum = '0;
      for (int c = 0; c < NUM_COL; c++) begin
         full[c] = cnt[c] == CNT_W'(NUM_ACC);
         take[c] = int'(col) == c + 1 && !full[c];
         sum = {1'b0, pot[c]} + {1'b0, partial};
         sat_sum[c] = sum[DATA_W] ? '1 : sum[DATA_W-1:0];
         spikes[NUM_COL-1-c] = pot[c] >= DATA_W'(THRESHOLD);
         fired[c] = !spikes[NUM_COL-1-c] ? pot[c] : RST_MODE != 0 ? '0 : pot[c] - DATA_W'(THRESHOLD);
         pots[(NUM_COL-1-c)*DATA_W+:DATA_W] = fired[c];
      end
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ACCUM;
         out_valid <= 1'b0;
         out_data <= '0;
         err <= 1'b0;
         for (int c = 0; c < NUM_COL; c++) begin
            pot[c] <= '0;
            cnt[c] <= '0;
         end
      end else begin
         err <= drop;
         case (state)
            ACCUM: begin
               for (int c = 0; c < NUM_COL; c++)
                  if (accept && take[c]) begin
                     pot[c] <= sat_sum[c];
                     cnt[c] <= cnt[c] + CNT_W'(1);
                  end
               if (&full) state <= FIRE;
            end
            FIRE: begin
               for (int c = 0; c < NUM_COL; c++) pot[c] <= fired[c];
               out_data <= {2'b11, 8'h00, ROW_W'(ROW), spikes, pots};
               out_valid <= 1'b1;
               state <= SEND;
            end
            SEND: if (out_ready) begin
               out_valid <= 1'b0;
               for (int c = 0; c < NUM_COL; c++) cnt[c] <= '0;
               state <= ACCUM;
            end
            default: state <= ACCUM;
         endcase
      end
   end
endmodule

// File: tb/tb_row_lif_accumulator.sv
// tb_row_lif_accumulator: directed checks of accumulation, thresholding, handshake, drops and reset
module tb_row_lif_accumulator;
   logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 1;
   logic [38:0] in_data = '0;
   logic in_ready, out_valid, err, in_ready_z, out_valid_z, err_z;
   logic [38:0] out_data, out_data_z;
   int checks = 0, failures = 0;
   always #5 clk = ~clk;
   row_lif_accumulator dut (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .err(err));
   row_lif_accumulator #(.RST_MODE(1)) dut_z (.clk(clk), .rst_n(rst_n), .in_valid(in_valid),
      .in_ready(in_ready_z), .in_data(in_data), .out_valid(out_valid_z), .out_ready(out_ready),
      .out_data(out_data_z), .err(err_z));
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   function automatic logic [38:0] pkt(input logic [2:0] s, input logic [7:0] a, b, c);
      return {2'b11, 8'h00, 2'b01, s, a, b, c};
   endfunction
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic send(input logic [1:0] col, input logic [7:0] v);
      in_valid = 1;
      in_data = '0;
      in_data[24+:2] = col;
      in_data[7:0] = v;
      tick();
      in_valid = 0;
   endtask
   task automatic step(input logic [71:0] v);
      for (int i = 0; i < 9; i++) send(2'(i / 3 + 1), v[71-8*i-:8]);
   endtask
   task automatic do_reset(input string tag);
      rst_n = 0;
      tick();
      check({tag, "_rst_in_ready"}, in_ready, 0);
      check({tag, "_rst_out_valid"}, out_valid, 0);
      check({tag, "_rst_out_data"}, out_data, 0);
      check({tag, "_rst_err"}, err, 0);
      rst_n = 1;
      #1;
      check({tag, "_post_rst_in_ready"}, in_ready, 1);
   endtask
   task automatic expect_pkt(input string tag, input logic [38:0] exp);
      check({tag, "_lat_not_yet"}, out_valid, 0);
      check({tag, "_in_ready_low"}, in_ready, 0);
      tick();
      check({tag, "_lat_early"}, out_valid, 0);
      tick();
      check({tag, "_out_valid"}, out_valid, 1);
      check({tag, "_out_data"}, out_data, exp);
      if (out_ready) begin
         tick();
         check({tag, "_done_valid"}, out_valid, 0);
         check({tag, "_done_in_ready"}, in_ready, 1);
      end
   endtask
   initial begin
      do_reset("init");
      // basic timestep with a held-off receiver
      out_ready = 0;
      step({8'd30, 8'd20, 8'd20, 8'd10, 8'd10, 8'd10, 8'd64, 8'd0, 8'd0});
      expect_pkt("basic", pkt(3'b101, 8'd6, 8'd30, 8'd0));
      for (int i = 0; i < 5; i++) begin
         in_valid = i[0];
         in_data = '0;
         in_data[24+:2] = 2'd1;
         in_data[7:0] = 8'd99;
         tick();
         check("hold_valid", out_valid, 1);
         check("hold_data", out_data, pkt(3'b101, 8'd6, 8'd30, 8'd0));
         check("hold_in_ready", in_ready, 0);
         check("hold_err", err, 0);
      end
      in_valid = 0;
      out_ready = 1;
      tick();
      check("hold_release_valid", out_valid, 0);
      check("hold_release_in_ready", in_ready, 1);
      // drops: column 0 and a fourth column-1 partial
      send(2'd0, 8'd50);
      check("drop_col0_err", err, 1);
      for (int i = 0; i < 3; i++) send(2'd1, 8'd1);
      check("accept_err_clear", err, 0);
      send(2'd1, 8'd100);
      check("drop_full_err", err, 1);
      tick();
      check("drop_err_pulse", err, 0);
      for (int i = 0; i < 6; i++) send(2'(i / 3 + 2), 8'd0);
      expect_pkt("after_drop", pkt(3'b000, 8'd9, 8'd30, 8'd0));
      // saturation, both reset modes
      do_reset("sat");
      step({8'd200, 8'd100, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0});
      expect_pkt("sat", pkt(3'b100, 8'd191, 8'd0, 8'd0));
      check("sat_zero_mode", out_data_z, pkt(3'b100, 8'd0, 8'd0, 8'd0));
      check("sat_zero_valid", out_valid_z, 0);
      // persistence across timesteps
      do_reset("persist");
      step({8'd0, 8'd0, 8'd0, 8'd10, 8'd10, 8'd10, 8'd0, 8'd0, 8'd0});
      expect_pkt("persist1", pkt(3'b000, 8'd0, 8'd30, 8'd0));
      step({8'd0, 8'd0, 8'd0, 8'd10, 8'd10, 8'd10, 8'd0, 8'd0, 8'd0});
      expect_pkt("persist2", pkt(3'b000, 8'd0, 8'd60, 8'd0));
      step({8'd0, 8'd0, 8'd0, 8'd10, 8'd10, 8'd10, 8'd0, 8'd0, 8'd0});
      expect_pkt("persist3", pkt(3'b010, 8'd0, 8'd26, 8'd0));
      // reset in the middle of ACCUM
      send(2'd1, 8'd40);
      send(2'd2, 8'd40);
      do_reset("mid_accum");
      step({8'd30, 8'd20, 8'd20, 8'd10, 8'd10, 8'd10, 8'd64, 8'd0, 8'd0});
      expect_pkt("after_accum_rst", pkt(3'b101, 8'd6, 8'd30, 8'd0));
      // reset while a packet waits in SEND
      out_ready = 0;
      step({8'd50, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0});
      expect_pkt("pre_send_rst", pkt(3'b000, 8'd56, 8'd30, 8'd0));
      out_ready = 1;
      do_reset("mid_send");
      step({8'd30, 8'd20, 8'd20, 8'd10, 8'd10, 8'd10, 8'd64, 8'd0, 8'd0});
      expect_pkt("after_send_rst", pkt(3'b101, 8'd6, 8'd30, 8'd0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
